led_fade_sequencer: RTL and testbench
=====================================

Name: led_fade_sequencer

Overview:
- Controller that drives the duty word and enable of one led_dimmer PWM instance to produce hardware "breathing" (fade in, hold, fade out, hold) with no CPU involvement.
- Runs on the same clock as the dimmer and sits between the register/control logic and led_dimmer.
- Duty changes occur only on PWM period boundaries, so the dimmer never sees a mid-period duty change.
- Supports one-shot and continuous modes, plus an abort input.

Parameters:
- DUTY_W, 4, width of the duty word; DUTY_MAX = 2**DUTY_W-1.
- PWM_PERIOD, 16, clocks per dimmer PWM period; must equal the dimmer's period.
- CFG_W, 8, width of the step_div and hold_per config inputs.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- stop  in  1  abort; honoured in any state.
- continuous  in  1  1 = loop forever, 0 = one fade cycle; latched at start.
- step_div  in  CFG_W  PWM periods per duty step; 0 is treated as 1; latched at start.
- hold_per  in  CFG_W  PWM periods to hold at MAX and at 0; 0 = no hold; latched at start.
- w  out  DUTY_W  duty word to led_dimmer.w.
- en  out  1  enable to led_dimmer.en.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when a one-shot sequence completes.

Behaviour:
- Reset (rst=1 at a posedge): state=IDLE, w=0, en=0, busy=0, done=0, all counters 0, config registers 0.
- Counters:
  - pcnt runs 0..PWM_PERIOD-1 while busy. A period tick is the edge where pcnt==PWM_PERIOD-1.
  - scnt counts ticks. A step completes on the tick where scnt==max(step_div,1)-1; scnt then clears.
  - hcnt counts ticks in hold states.
- States are IDLE, RAMP_UP, HOLD_HI, RAMP_DN, HOLD_LO.
- IDLE:
  - On start & !stop at edge T: latch config; w=0; en=1; pcnt=scnt=0; go to RAMP_UP.
  - pcnt after edge T+k equals k mod PWM_PERIOD.
- RAMP_UP, on step completion:
  - If w<MAX: w=w+1.
  - If w==MAX and hold_per!=0: go to HOLD_HI.
  - If w==MAX and hold_per==0: go to RAMP_DN with w=MAX-1 on the same edge.
- HOLD_HI: w stays MAX. On the hold_per-th tick: go to RAMP_DN with w=MAX-1 on that edge.
- RAMP_DN, on step completion:
  - If w>0: w=w-1.
  - If w==0 and one-shot: go to IDLE; en=0; done=1 for exactly one cycle.
  - If w==0 and continuous and hold_per!=0: go to HOLD_LO.
  - If w==0 and continuous and hold_per==0: go to RAMP_UP with w=1.
- HOLD_LO: w stays 0 and en stays 1. On the hold_per-th tick: go to RAMP_UP with w=1.
- Every state transition clears scnt and hcnt; pcnt keeps running, so period alignment is preserved.
- stop:
  - At any edge, stop=1 forces IDLE, w=0, en=0, done=0 on that edge.
  - stop takes priority over start in the same cycle.
  - done is never asserted on an abort.
- start while busy is ignored; config inputs changing while busy have no effect.
- Latency: start→en=1 is 1 cycle. Output w changes only on tick edges (or on the start/stop edges).
- rst mid-sequence behaves exactly like reset from power-up.
- Worst-case step length is 255 periods. Counters must not overflow, so scnt and hcnt are CFG_W bits.

Decomposition:
- Package led_pwm_pkg holds:
  - the state enum (fade_state_t);
  - DUTY_MAX derivation, shared with led_dimmer.
- One sub-module, pwm_period_tick: the free-running period counter with a synchronous clear and a tick output. The dimmer can reuse it.

Test Plan:
- Baseline ramp: rst, then start at edge T with step_div=2, hold_per=3, continuous=0 → w=1 after T+32, w=k after T+32k, w=15 after T+480, HOLD_HI from T+512, w=14 after T+560.
- Ramp-down and done (same run): w=0 after T+1008; at T+1040 state=IDLE, en=0, busy=0; done high for exactly 1 cycle.
- Continuous, hold_per=0, step_div=1 → 15→14 on the same edge as the MAX step completion; 0→1 with no HOLD_LO; triangle period is 30 PWM periods (480 clocks), checked over 3 loops.
- step_div=0 → identical timing to step_div=1 (w increments every 16 clocks).
- Abort: stop asserted mid-RAMP_UP (w=7), with start also high → next cycle w=0, en=0, busy=0, done=0. A later start restarts from w=0.
- Reset mid-HOLD_HI, and start pulsed while busy → reset clears all outputs; a start while busy causes no restart or timing shift (w sequence unchanged).

Source files
------------

// File: rtl/led_pwm_pkg.sv
// Shared types and helpers for the LED PWM blocks (fade sequencer, dimmer).
package led_pwm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RAMP_UP = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_RAMP_DN = 3'd3,
        ST_HOLD_LO = 3'd4
    } fade_state_t;

    function automatic int duty_max(input int duty_w);
        return (1 << duty_w) - 1;
    endfunction

endpackage

// File: rtl/pwm_period_tick.sv
// Free-running PWM period counter with synchronous clear; tick marks the last clock of a period.
module pwm_period_tick #(
    parameter int PERIOD = 16,
    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/led_fade_sequencer.sv
// Breathing-effect controller for one led_dimmer: ramps duty up/down on PWM period boundaries.
//   state      | meaning
//   ST_IDLE    | outputs parked, waiting for start
//   ST_RAMP_UP | duty rising one step every step_div periods
//   ST_HOLD_HI | duty at MAX for hold_per periods
//   ST_RAMP_DN | duty falling one step every step_div periods
//   ST_HOLD_LO | duty at 0 (still enabled) for hold_per periods, continuous mode only
module led_fade_sequencer
    import led_pwm_pkg::*;
#(
    parameter int DUTY_W     = 4,
    parameter int PWM_PERIOD = 16,
    parameter int CFG_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              continuous,
    input  logic [CFG_W-1:0]  step_div,
    input  logic [CFG_W-1:0]  hold_per,
    output logic [DUTY_W-1:0] w,
    output logic              en,
    output logic              busy,
    output logic              done
);

    localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(duty_max(DUTY_W));
    localparam int PCNT_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;

    fade_state_t       state;
    logic [CFG_W-1:0]  step_cfg;
    logic [CFG_W-1:0]  hold_cfg;
    logic              cont_cfg;
    logic [CFG_W-1:0]  scnt;
    logic [CFG_W-1:0]  hcnt;
    logic [PCNT_W-1:0] pcnt;
    logic              tick;
    logic              pwm_clr;
    logic [CFG_W-1:0]  step_last;
    logic              step_end;
    logic              hold_end;

    // Period counter only runs while a sequence is active, so every sequence starts period-aligned.
    assign pwm_clr = (state == ST_IDLE) || stop;

    pwm_period_tick #(.PERIOD(PWM_PERIOD)) u_period (
        .clk  (clk),
        .rst  (rst),
        .clr  (pwm_clr),
        .cnt  (pcnt),
        .tick (tick)
    );

    assign step_last = (step_cfg == '0) ? '0 : step_cfg - 1'b1;
    assign step_end  = tick && (scnt == step_last);
    assign hold_end  = tick && (hcnt == hold_cfg - 1'b1);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            w        <= '0;
            en       <= 1'b0;
            done     <= 1'b0;
            scnt     <= '0;
            hcnt     <= '0;
            step_cfg <= '0;
            hold_cfg <= '0;
            cont_cfg <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state <= ST_IDLE;
                w     <= '0;
                en    <= 1'b0;
                scnt  <= '0;
                hcnt  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            step_cfg <= step_div;
                            hold_cfg <= hold_per;
                            cont_cfg <= continuous;
                            w        <= '0;
                            en       <= 1'b1;
                            scnt     <= '0;
                            hcnt     <= '0;
                            state    <= ST_RAMP_UP;
                        end
                    end
                    ST_RAMP_UP: begin
                        if (step_end) begin
                            scnt <= '0;
                            hcnt <= '0;
                            if (w != DUTY_MAX) begin
                                w <= w + 1'b1;
                            end else if (hold_cfg != '0) begin
                                state <= ST_HOLD_HI;
                            end else begin
                                state <= ST_RAMP_DN;
                                w     <= DUTY_MAX - 1'b1;
                            end
                        end else if (tick) begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                    ST_HOLD_HI: begin
                        if (hold_end) begin
                            state <= ST_RAMP_DN;
                            w     <= DUTY_MAX - 1'b1;
                            scnt  <= '0;
                            hcnt  <= '0;
                        end else if (tick) begin
                            hcnt <= hcnt + 1'b1;
                        end
                    end
                    ST_RAMP_DN: begin
                        if (step_end) begin
                            scnt <= '0;
                            hcnt <= '0;
                            if (w != '0) begin
                                w <= w - 1'b1;
                            end else if (!cont_cfg) begin
                                state <= ST_IDLE;
                                en    <= 1'b0;
                                done  <= 1'b1;
                            end else if (hold_cfg != '0) begin
                                state <= ST_HOLD_LO;
                            end else begin
                                state <= ST_RAMP_UP;
                                w     <= DUTY_W'(1);
                            end
                        end else if (tick) begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                    ST_HOLD_LO: begin
                        if (hold_end) begin
                            state <= ST_RAMP_UP;
                            w     <= DUTY_W'(1);
                            scnt  <= '0;
                            hcnt  <= '0;
                        end else if (tick) begin
                            hcnt <= hcnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        w     <= '0;
                        en    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // The period counter must be parked whenever the sequencer is idle.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_IDLE) begin
            assert (pcnt == '0);
        end
    end

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Randomized self-checking bench for led_fade_sequencer against a per-period duty trajectory model.
module tb_led_fade_sequencer;

    localparam int DUTY_W     = 4;
    localparam int PWM_PERIOD = 16;
    localparam int CFG_W      = 8;
    localparam int MAXV       = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              continuous = 1'b0;
    logic [CFG_W-1:0]  step_div = '0;
    logic [CFG_W-1:0]  hold_per = '0;
    logic [DUTY_W-1:0] w;
    logic              en;
    logic              busy;
    logic              done;

    int checks = 0;
    int failures = 0;
    int exp_q[$];

    led_fade_sequencer #(
        .DUTY_W(DUTY_W), .PWM_PERIOD(PWM_PERIOD), .CFG_W(CFG_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
        .step_div(step_div), .hold_per(hold_per), .w(w), .en(en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One queue entry per PWM period after start: the duty seen during that period.
    task automatic build_model(input int sdiv, input int hold, input bit cont, input int min_len);
        int s;
        s = (sdiv == 0) ? 1 : sdiv;
        exp_q.delete();
        repeat (s) exp_q.push_back(0);
        do begin
            for (int v = 1; v < MAXV; v++) repeat (s) exp_q.push_back(v);
            repeat (s + hold) exp_q.push_back(MAXV);
            for (int v = MAXV - 1; v >= 1; v--) repeat (s) exp_q.push_back(v);
            repeat (s) exp_q.push_back(0);
            if (cont) repeat (hold) exp_q.push_back(0);
        end while (cont && exp_q.size() < min_len);
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (w !== 4'd0 || en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s: got w=%0d en=%0b busy=%0b done=%0b, want w=0 en=0 busy=0 done=0",
                     name, w, en, busy, done);
        end
    endtask

    // Starts a sequence and compares outputs every clock; ncyc<0 runs a one-shot to completion.
    task automatic run_check(input int sdiv, input int hold, input bit cont, input int ncyc_in,
                             input bit noise, input string name, output int done_cnt);
        int len, ncyc, ew;
        bit een, ebusy, edone;
        build_model(sdiv, hold, cont, (ncyc_in / PWM_PERIOD) + 2);
        len = exp_q.size() * PWM_PERIOD;
        ncyc = (ncyc_in < 0) ? len + 3 : ncyc_in;
        done_cnt = 0;
        step_div = CFG_W'(sdiv);
        hold_per = CFG_W'(hold);
        continuous = cont;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k <= ncyc; k++) begin
            if (!cont && k >= len) begin
                ew = 0; een = 0; ebusy = 0; edone = (k == len);
            end else begin
                ew = exp_q[k / PWM_PERIOD]; een = 1; ebusy = 1; edone = 0;
            end
            if (done === 1'b1) done_cnt++;
            checks++;
            if (w !== 4'(ew) || en !== een || busy !== ebusy || done !== edone) begin
                failures++;
                $display("FAIL %s k=%0d: got w=%0d en=%0b busy=%0b done=%0b, want w=%0d en=%0b busy=%0b done=%0b",
                         name, k, w, en, busy, done, ew, een, ebusy, edone);
            end
            if (noise && (cont || k < len)) begin
                start = 1'($urandom_range(0, 1));
                continuous = 1'($urandom_range(0, 1));
                step_div = CFG_W'($urandom_range(0, 255));
                hold_per = CFG_W'($urandom_range(0, 255));
            end else begin
                start = 1'b0;
            end
            if (k < ncyc) step();
        end
        start = 1'b0;
    endtask

    task automatic do_stop(input bit with_start, input string name);
        stop = 1'b1;
        start = with_start;
        step();
        stop = 1'b0;
        start = 1'b0;
        check_idle(name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        check_idle("reset_state");
        rst = 1'b0;
        step();
        check_idle("idle_after_reset");
    endtask

    task automatic test_baseline();
        int dc;
        run_check(2, 3, 1'b0, -1, 1'b0, "baseline", dc);
        checks++;
        if (dc != 1) begin
            failures++;
            $display("FAIL baseline_done_count: got %0d pulses, want 1", dc);
        end
    endtask

    task automatic test_continuous();
        int dc;
        run_check(1, 0, 1'b1, 3 * 480 + 20, 1'b1, "continuous_tri", dc);
        checks++;
        if (dc != 0) begin
            failures++;
            $display("FAIL continuous_no_done: got %0d pulses, want 0", dc);
        end
        do_stop(1'b0, "continuous_stop");
    endtask

    task automatic test_step_div_zero();
        int dc;
        run_check(0, 2, 1'b0, -1, 1'b0, "step_div_zero", dc);
    endtask

    task automatic test_abort();
        int dc;
        run_check(1, 0, 1'b1, 7 * PWM_PERIOD + 5, 1'b0, "abort_pre", dc);
        checks++;
        if (w !== 4'd7) begin
            failures++;
            $display("FAIL abort_precondition: got w=%0d, want 7", w);
        end
        do_stop(1'b1, "abort_with_start");
        repeat (3) begin
            step();
            check_idle("abort_stays_idle");
        end
        run_check(1, 0, 1'b0, -1, 1'b0, "restart_after_abort", dc);
    endtask

    task automatic test_reset_mid_hold();
        int dc;
        run_check(1, 8, 1'b0, 17 * PWM_PERIOD + 3, 1'b1, "hold_hi_pre", dc);
        rst = 1'b1;
        start = 1'b1;
        step();
        check_idle("reset_mid_hold");
        rst = 1'b0;
        start = 1'b0;
        step();
        check_idle("idle_after_mid_reset");
        run_check(3, 1, 1'b0, -1, 1'b1, "after_mid_reset", dc);
    endtask

    task automatic test_random();
        int dc, s, h;
        bit c, nz;
        for (int i = 0; i < 5; i++) begin
            s = $urandom_range(0, 3);
            h = $urandom_range(0, 4);
            c = 1'($urandom_range(0, 1));
            nz = 1'($urandom_range(0, 1));
            run_check(s, h, c, c ? 40 * PWM_PERIOD : -1, nz, "random_run", dc);
            if (c) do_stop(1'($urandom_range(0, 1)), "random_stop");
            step();
        end
    endtask

    initial begin
        test_reset();
        test_baseline();
        test_continuous();
        test_step_div_zero();
        test_abort();
        test_reset_mid_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
